// File: rtl/shwr_int_pkg.sv
// Shared types and constants for the shower-signal integrator.
package shwr_int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INTEG = 2'd1,
    HOLD  = 2'd2
  } shwr_state_e;

  localparam int WIN_W = 12;
  localparam int SH_W  = 5;

  function automatic int one_half(input int frac_w);
    return 1 << (frac_w - 1);
  endfunction

  // Half an LSB of the reported baseline, expressed in internal fractional LSBs.
  function automatic int rnd_const(input int frac_w, input int extra_w);
    return 1 << (frac_w - extra_w - 1);
  endfunction

endpackage

// File: rtl/shwr_int_chan.sv
// One integrator channel: sample delay, baseline tracker, peak/saturation and clamped integral.
// Sag correction is built only when SHWR_INT_SAG_CORR_EN is defined.
module shwr_int_chan
  import shwr_int_pkg::*;
#(
  parameter int ADC_W     = 12,
  parameter int FRAC_W    = 6,
  parameter int EXTRA_W   = 2,
  parameter int AREA_W    = 19,
  parameter int DLY       = 4,
  parameter int BL_STEP   = 2,
  parameter int SAT_LEVEL = 4095,
  parameter logic [3*SH_W-1:0] SAG_SH_LO = {5'd10, 5'd12, 5'd14},
  parameter logic [3*SH_W-1:0] SAG_SH_HI = {5'd11, 5'd13, 5'd15}
) (
  input  logic                       CLK120,
  input  logic                       RESET,
  input  logic [ADC_W-1:0]           adc,
  input  logic                       hilo,
  input  logic                       track,
  input  logic                       clr,
  input  logic                       en,
  output logic [AREA_W-1:0]          integral,
  output logic [ADC_W+EXTRA_W-1:0]   baseline,
  output logic [ADC_W+EXTRA_W-1:0]   sbaseline,
  output logic [ADC_W-1:0]           peak,
  output logic                       saturated
);

  localparam int LBL_W  = ADC_W + FRAC_W;
  localparam int OUT_W  = ADC_W + EXTRA_W;
  localparam int SAG_W  = LBL_W + WIN_W;
  localparam int ACC_W  = SAG_W + 8;
  localparam int SHR_BL = FRAC_W - EXTRA_W;
  localparam logic signed [LBL_W:0] HALF  = (LBL_W+1)'(one_half(FRAC_W));
  localparam logic signed [LBL_W:0] NHALF = -HALF;
  localparam logic signed [LBL_W:0] ZERO  = '0;
  localparam logic [LBL_W-1:0] STEP1   = LBL_W'(1 << BL_STEP);
  localparam logic [LBL_W-1:0] STEP2   = LBL_W'(2 << BL_STEP);
  localparam logic [LBL_W-1:0] RND_BL  = LBL_W'(rnd_const(FRAC_W, EXTRA_W));
  localparam logic [LBL_W-1:0] RND_INT = LBL_W'(one_half(FRAC_W));
  localparam logic [ADC_W-1:0] SAT_ADC = ADC_W'(SAT_LEVEL);
  localparam logic signed [ACC_W-1:0] AREA_MAX = ACC_W'((64'd1 << AREA_W) - 64'd1);

  logic [ADC_W-1:0]         dly [DLY+1];
  logic [ADC_W-1:0]         adc_d, rbl, pk_raw;
  logic [LBL_W-1:0]         sample_f, lbl, lbl_nxt, bl_sum, rb_sum;
  logic signed [LBL_W:0]    err;
  logic signed [SAG_W:0]    cbl;
  logic signed [ACC_W-1:0]  acc, acc_int;
  logic [AREA_W-1:0]        int_c;
  logic [OUT_W-1:0]         sbl_c;
  logic [3*SH_W-1:0]        sh_sel;

  assign adc_d    = dly[DLY];
  assign sample_f = {adc_d, {FRAC_W{1'b0}}};
  assign err      = $signed({1'b0, sample_f}) - $signed({1'b0, lbl});
  assign bl_sum   = lbl + RND_BL;
  assign rb_sum   = lbl + RND_INT;
  assign rbl      = ADC_W'(rb_sum >> FRAC_W);
  assign sh_sel   = hilo ? SAG_SH_HI : SAG_SH_LO;
  assign acc_int  = acc >>> FRAC_W;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      for (int i = 0; i <= DLY; i++) dly[i] <= '0;
    end else begin
      dly[0] <= adc;
      for (int i = 1; i <= DLY; i++) dly[i] <= dly[i-1];
    end
  end

  always_comb begin
    lbl_nxt = lbl;
    if (track) begin
      if (err > HALF)       lbl_nxt = lbl + STEP2;
      else if (err > ZERO)  lbl_nxt = lbl + STEP1;
      else if (err < NHALF) lbl_nxt = lbl - STEP2;
      else if (err < ZERO)  lbl_nxt = lbl - STEP1;
    end
  end

`ifdef SHWR_INT_SAG_CORR_EN
  logic [SAG_W-1:0] sag, sag_inc;
  logic [LBL_W-1:0] diff;
  logic [SAG_W:0]   sb_sum;

  assign diff    = sample_f - lbl;
  assign sag_inc = SAG_W'(diff >> sh_sel[0 +: SH_W]) + SAG_W'(diff >> sh_sel[SH_W +: SH_W])
                 + SAG_W'(diff >> sh_sel[2*SH_W +: SH_W]);
  assign cbl     = $signed({1'b0, SAG_W'(lbl)}) - $signed({1'b0, sag});
  assign sb_sum  = cbl + (SAG_W+1)'(rnd_const(FRAC_W, EXTRA_W));
  assign sbl_c   = cbl[SAG_W] ? '0 : OUT_W'(sb_sum >> SHR_BL);

  always_ff @(posedge CLK120) begin
    if (RESET || clr)                sag <= '0;
    else if (en && sample_f > lbl)   sag <= sag + sag_inc;
  end
`else
  logic unused_sag;
  assign unused_sag = ^sh_sel;
  assign cbl        = $signed({1'b0, SAG_W'(lbl)});
  assign sbl_c      = OUT_W'(bl_sum >> SHR_BL);
`endif

  // Negative charge reads as zero; overflow saturates instead of wrapping.
  always_comb begin
    int_c = AREA_W'(acc_int);
    if (acc[ACC_W-1])           int_c = '0;
    else if (acc_int > AREA_MAX) int_c = '1;
  end

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      lbl       <= '0;
      baseline  <= '0;
      sbaseline <= '0;
      pk_raw    <= '0;
      peak      <= '0;
      saturated <= 1'b0;
      acc       <= '0;
      integral  <= '0;
    end else begin
      lbl       <= lbl_nxt;
      baseline  <= OUT_W'(bl_sum >> SHR_BL);
      sbaseline <= sbl_c;
      if (clr) begin
        pk_raw    <= '0;
        peak      <= '0;
        saturated <= 1'b0;
        acc       <= '0;
        integral  <= '0;
      end else begin
        integral <= int_c;
        if (en) begin
          acc <= acc + ACC_W'(sample_f) - ACC_W'(cbl);
          if (adc_d > pk_raw && adc_d > rbl) begin
            pk_raw <= adc_d;
            peak   <= adc_d - rbl;
          end
          if (adc_d >= SAT_ADC) saturated <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/shwr_integral_mc.sv
// Multi-channel shower integrator: shared IDLE/INTEG/HOLD sequencer over NCH channel datapaths.
// Define SHWR_INT_SAG_CORR_EN to build the droop (sag) correction into every channel.
module shwr_integral_mc
  import shwr_int_pkg::*;
#(
  parameter int NCH       = 3,
  parameter int ADC_W     = 12,
  parameter int FRAC_W    = 6,
  parameter int EXTRA_W   = 2,
  parameter int AREA_W    = 19,
  parameter int DLY       = 4,
  parameter int BL_STEP   = 2,
  parameter int SAT_LEVEL = 4095,
  parameter logic [3*SH_W-1:0] SAG_SH_LO = {5'd10, 5'd12, 5'd14},
  parameter logic [3*SH_W-1:0] SAG_SH_HI = {5'd11, 5'd13, 5'd15}
) (
  input  logic                           CLK120,
  input  logic                           RESET,
  input  logic [NCH*ADC_W-1:0]           ADC,
  input  logic [NCH-1:0]                 HILO,
  input  logic                           TRIGGERED,
  input  logic [WIN_W-1:0]               WINDOW,
  output logic [NCH*AREA_W-1:0]          INTEGRAL,
  output logic [NCH*(ADC_W+EXTRA_W)-1:0] BASELINE,
  output logic [NCH*(ADC_W+EXTRA_W)-1:0] SBASELINE,
  output logic [NCH*ADC_W-1:0]           PEAK,
  output logic [NCH-1:0]                 SATURATED,
  output logic                           BUSY,
  output logic                           DONE
);

  localparam int OUT_W = ADC_W + EXTRA_W;

  shwr_state_e      state_q, state_nxt;
  logic             trig_q, clr, en, fin, done_q, track;
  logic [WIN_W-1:0] win_q, cnt_q;

  always_ff @(posedge CLK120) begin
    if (RESET) begin
      state_q <= IDLE;
      trig_q  <= 1'b0;
      win_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      trig_q  <= TRIGGERED;
      done_q  <= fin;
      if (clr) begin
        win_q <= WINDOW;
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + WIN_W'(1);
      end
    end
  end

  // DONE is registered so it lands on the same cycle as the final INTEGRAL.
  always_comb begin
    state_nxt = state_q;
    clr       = 1'b0;
    en        = 1'b0;
    fin       = 1'b0;
    case (state_q)
      IDLE: begin
        if (TRIGGERED && !trig_q) begin
          clr       = 1'b1;
          state_nxt = INTEG;
        end
      end
      INTEG: begin
        if (cnt_q == win_q || !TRIGGERED) begin
          fin       = 1'b1;
          state_nxt = HOLD;
        end else begin
          en = 1'b1;
        end
      end
      HOLD: begin
        if (!TRIGGERED) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign track = (state_q == IDLE);
  assign BUSY  = (state_q == INTEG);
  assign DONE  = done_q;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    shwr_int_chan #(
      .ADC_W(ADC_W), .FRAC_W(FRAC_W), .EXTRA_W(EXTRA_W), .AREA_W(AREA_W), .DLY(DLY),
      .BL_STEP(BL_STEP), .SAT_LEVEL(SAT_LEVEL), .SAG_SH_LO(SAG_SH_LO), .SAG_SH_HI(SAG_SH_HI)
    ) u_chan (
      .CLK120    (CLK120),
      .RESET     (RESET),
      .adc       (ADC[g*ADC_W +: ADC_W]),
      .hilo      (HILO[g]),
      .track     (track),
      .clr       (clr),
      .en        (en),
      .integral  (INTEGRAL[g*AREA_W +: AREA_W]),
      .baseline  (BASELINE[g*OUT_W +: OUT_W]),
      .sbaseline (SBASELINE[g*OUT_W +: OUT_W]),
      .peak      (PEAK[g*ADC_W +: ADC_W]),
      .saturated (SATURATED[g])
    );
  end

endmodule
